// File: rtl/fp_normalizer.sv
// fp_normalizer -- post-add normalize/pack stage of the FP adder path.
//
// Takes the raw mantissa sum (hidden bit plus carry), the common exponent and the sign from
// the mantissa adder. It normalizes one step per cycle and returns a packed IEEE-754 word
// {sign, exp, frac} over a valid/ready handshake.
//
// Normalization steps:
//   - a carry out causes one right shift;
//   - otherwise the stage shifts left one bit per cycle until the hidden bit is set, or the
//     exponent reaches 1 (denormal result).
//
// Build option:
//   FP_NORM_ROUND_NEAREST_EN  when defined, a carry right shift rounds half-to-even on the
//                             dropped bit. When undefined, the dropped bit is truncated.
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   in_valid     sum_in/exp_in/sign_in/is_sub are valid
//   in_ready     stage is idle and can accept an operation
//   sum_in       adder output, MAN_W+2 bits; bit MAN_W+1 is the carry
//   exp_in       common (larger) exponent after alignment
//   sign_in      result sign
//   is_sub       adder performed a subtraction; the carry bit is discarded
//   out_valid    result is valid; held until out_ready
//   out_ready    downstream accepts the result
//   result       packed {sign, exp, frac}
//   overflow     result saturated to infinity
//   underflow    result is denormal with a nonzero fraction
//   zero         result is exactly +0

module fp_normalizer #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAN_W+1:0]       sum_in,
  input  logic [EXP_W-1:0]       exp_in,
  input  logic                   sign_in,
  input  logic                   is_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   zero
);

  // The exponent carries one extra bit so that a carry into all-ones cannot wrap.
  localparam logic [EXP_W:0]   ExpOne  = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0]   ExpMax  = {1'b0, {EXP_W{1'b1}}};
`ifdef FP_NORM_ROUND_NEAREST_EN
  localparam logic [MAN_W+1:0] MantOne = {{(MAN_W+1){1'b0}}, 1'b1};
`endif

  typedef enum logic [1:0] {StIdle, StEval, StShift, StDone} state_e;

  // Selects how the DONE state packs the working mantissa/exponent.
  typedef enum logic [1:0] {KindNorm, KindZero, KindOvf, KindDenorm} kind_e;

  state_e               state_q;
  kind_e                kind_q;
  logic [MAN_W+1:0]     mant_q;
  logic [EXP_W:0]       exp_q;
  logic                 sign_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [EXP_W+MAN_W:0] result_q;
  logic                 overflow_q;
  logic                 underflow_q;
  logic                 zero_q;

  logic [MAN_W+1:0]     carry_mant;
  logic [EXP_W:0]       carry_exp;
  logic [MAN_W+1:0]     shift_mant;
  logic [EXP_W:0]       shift_exp;
  logic [MAN_W-1:0]     frac;
  logic [EXP_W+MAN_W:0] pack;

  // Carry path: a 1-bit right shift, with an optional rounding step.
  // Both happen within the EVAL cycle.
  always_comb begin
    carry_mant = {1'b0, mant_q[MAN_W+1:1]};
    carry_exp  = exp_q + ExpOne;
`ifdef FP_NORM_ROUND_NEAREST_EN
    // With only a guard bit there is no sticky, so guard=1 is always a tie; round to even.
    if (mant_q[0] && carry_mant[0]) begin
      carry_mant = carry_mant + MantOne;
      // Rounding up from 1.111..1 lands on 2.0; renormalize once more.
      if (carry_mant[MAN_W+1]) begin
        carry_mant = {1'b0, carry_mant[MAN_W+1:1]};
        carry_exp  = carry_exp + ExpOne;
      end
    end
`endif
  end

  // Left-normalize path. The carry bit is always clear by the time SHIFT runs.
  always_comb begin
    shift_mant = {mant_q[MAN_W:0], 1'b0};
    shift_exp  = exp_q - ExpOne;
  end

  always_comb begin
    frac = mant_q[MAN_W-1:0];
    unique case (kind_q)
      KindZero:   pack = '0;
      KindOvf:    pack = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      KindDenorm: pack = {sign_q, {EXP_W{1'b0}}, frac};
      default:    pack = {sign_q, exp_q[EXP_W-1:0], frac};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      kind_q      <= KindNorm;
      mant_q      <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            mant_q     <= is_sub ? {1'b0, sum_in[MAN_W:0]} : sum_in;
            exp_q      <= {1'b0, exp_in};
            sign_q     <= sign_in;
            kind_q     <= KindNorm;
            in_ready_q <= 1'b0;
            state_q    <= StEval;
          end
        end

        StEval: begin
          if (mant_q == '0) begin
            kind_q  <= KindZero;
            sign_q  <= 1'b0;
            state_q <= StDone;
          end else if (mant_q[MAN_W+1]) begin
            mant_q <= carry_mant;
            exp_q  <= carry_exp;
            if (carry_exp >= ExpMax) begin
              kind_q <= KindOvf;
            end
            state_q <= StDone;
          end else if (mant_q[MAN_W]) begin
            state_q <= StDone;
          end else if (exp_q <= ExpOne) begin
            // Covers exp_in == 0: packed as denormal without shifting.
            kind_q  <= KindDenorm;
            state_q <= StDone;
          end else begin
            state_q <= StShift;
          end
        end

        StShift: begin
          mant_q <= shift_mant;
          exp_q  <= shift_exp;
          if (shift_mant[MAN_W]) begin
            state_q <= StDone;
          end else if (shift_exp == ExpOne) begin
            kind_q  <= KindDenorm;
            state_q <= StDone;
          end
        end

        StDone: begin
          // The first DONE cycle registers the packed word. After that, the outputs are
          // held until the handshake completes.
          if (!out_valid_q) begin
            result_q    <= pack;
            overflow_q  <= (kind_q == KindOvf);
            underflow_q <= (kind_q == KindDenorm) && (frac != '0);
            zero_q      <= (kind_q == KindZero);
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign zero      = zero_q;

endmodule
